// File: rtl/seg_scan_mux_pkg.sv
// Shared constants for the 7-segment scan driver and its helpers.
package seg_scan_mux_pkg;

  typedef logic [3:0] nibble_t;

  localparam int unsigned DIGITS_DEF = 4;
  localparam logic        DP_OFF     = 1'b1;
  localparam nibble_t     HEX_RST    = 4'h0;

endpackage

// File: rtl/seg_scan_mux_tick_gen.sv
// Free-running prescaler: counts 0..REFRESH_DIV-1, tick marks the last count.
module tick_gen #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick,
  output logic [DIV_W-1:0] cnt
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == DIV_W'(REFRESH_DIV - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode display scanner: frame-synchronous value update,
// anti-ghosting blank gap and leading-zero suppression, all outputs registered.
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int unsigned DIGITS      = DIGITS_DEF,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  value_vld,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic             tick;
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  nibble_t             hex_q, hex_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;
  logic [DIGITS-1:0]   lz_mask;
  logic                zero_above;

  tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .DIV_W       (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .cnt  (cnt)
  );

  assign wrap = tick && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    idx_d  = idx_q;
    pend_d = pend_q;
    disp_d = disp_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    if (value_vld) pend_d = value;
    // a strobe landing on the boundary bypasses pend so it shows this frame
    if (wrap) disp_d = value_vld ? value : pend_q;
  end

  // Walk from the most significant digit down; digit 0 is never suppressed.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_blank & zero_above;
    end
  end

  always_comb begin
    hex_d = disp_q[{idx_q, 2'b00} +: 4];
    dp_d  = lz_mask[idx_q] ? DP_OFF : ~dp_in[idx_q];
    an_d  = '1;
    if ((cnt >= DIV_W'(BLANK_CYC)) && !lz_mask[idx_q]) an_d[idx_q] = 1'b0;
    fs_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pend_q <= '0;
      disp_q <= '0;
      hex_q  <= HEX_RST;
      an_q   <= '1;
      dp_q   <= DP_OFF;
      fs_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      hex_q  <= hex_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign hex         = hex_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised scoreboard bench for seg_scan_mux against a time-based display model.
module tb_seg_scan_mux;

  localparam int unsigned D    = 4;
  localparam int unsigned RD   = 4;
  localparam int unsigned BC   = 1;
  localparam int unsigned NCYC = 2500;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        value_vld;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .DIGITS      (D),
    .REFRESH_DIV (RD),
    .BLANK_CYC   (BC),
    .DIV_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_vld   (value_vld),
    .dp_in       (dp_in),
    .lz_blank    (lz_blank),
    .hex         (hex),
    .an          (an),
    .dp          (dp),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] hex;
    logic [3:0] an;
    logic       dp;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: cycles since reset release, pending and displayed values.
  int unsigned t_m    = 0;
  logic [15:0] pend_m = '0;
  logic [15:0] disp_m = '0;

  function automatic logic [15:0] pick_value();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(4))
      0:       return r;
      1:       return r & 16'h00FF;
      2:       return 16'h0050;
      3:       return 16'h0000;
      default: return r & 16'h0F0F;
    endcase
  endfunction

  function automatic logic at_boundary();
    return ((t_m % RD) == RD - 1) && (((t_m / RD) % D) == D - 1);
  endfunction

  // Expected registered outputs after the coming edge, from this cycle's inputs.
  task automatic push_expected();
    obs_t        e;
    int unsigned ph, dg;
    logic        bl;
    if (rst) begin
      e      = '{hex: 4'h0, an: 4'hF, dp: 1'b1, fs: 1'b0};
      t_m    = 0;
      pend_m = '0;
      disp_m = '0;
    end else begin
      ph    = t_m % RD;
      dg    = (t_m / RD) % D;
      bl    = lz_blank && (dg >= 1) && ((disp_m >> (4 * dg)) == 16'h0);
      e.hex = 4'((disp_m >> (4 * dg)) & 16'h000F);
      e.an  = (ph >= BC && !bl) ? ~(4'(1) << dg) : 4'hF;
      e.dp  = bl ? 1'b1 : ~dp_in[dg];
      e.fs  = (ph == RD - 1) && (dg == D - 1);
      if (e.fs) disp_m = value_vld ? value : pend_m;
      if (value_vld) pend_m = value;
      t_m++;
    end
    exp_q.push_back(e);
  endtask

  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      got = {hex, an, dp, frame_start};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow t=%0t got hex=%h an=%b dp=%b fs=%b", $time,
                 hex, an, dp, frame_start);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL scan_out t=%0t got hex=%h an=%b dp=%b fs=%b want hex=%h an=%b dp=%b fs=%b",
                   $time, got.hex, got.an, got.dp, got.fs, e.hex, e.an, e.dp, e.fs);
        end
      end
    end
  end

  initial begin
    logic bnd;
    rst       = 1'b1;
    value     = '0;
    value_vld = 1'b0;
    dp_in     = '0;
    lz_blank  = 1'b0;
    for (int c = 0; c < int'(NCYC); c++) begin
      bnd       = at_boundary();
      rst       = (c < 3) || ($urandom_range(199) == 0);
      value     = pick_value();
      value_vld = bnd ? 1'($urandom_range(1)) : ($urandom_range(9) == 0);
      if ($urandom_range(31) == 0) dp_in = 4'($urandom);
      if ($urandom_range(63) == 0) lz_blank = ~lz_blank;
      push_expected();
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
